// File: rtl/ftrace_sched.sv
// Function-trace event scheduler: classifies committed jal/jalr events, buffers them and drains one per cycle.
// Define FTRACE_DEPTH_EN to implement the call-depth counter; otherwise depth is tied to zero.
module ftrace_sched #(
   parameter int DEPTH = 8,
   parameter int DROPW = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_is_jal,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_nextpc,
   input  logic [31:0]       in_inst,
   input  logic [31:0]       in_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_nextpc,
   output logic [31:0]       out_inst,
   output logic [31:0]       out_rd,
   output logic              out_is_jal,
   output logic [1:0]        out_kind,
   output logic [7:0]        depth,
   output logic              overflow,
   output logic [DROPW-1:0]  drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [1:0] KIND_JUMP = 2'b00;
   localparam logic [1:0] KIND_CALL = 2'b01;
   localparam logic [1:0] KIND_RET  = 2'b10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] nextpc;
      logic [31:0] inst;
      logic [31:0] rd;
      logic        is_jal;
      logic [1:0]  kind;
   } entry_t;

   localparam entry_t ENTRY_ZERO = {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00};

   // Link registers are x1 and x5 (RISC-V calling convention hint).
   function automatic logic [1:0] classify(input logic is_jal, input logic [31:0] inst);
      logic rd_link;
      logic rs1_link;
      logic rd_zero;
      rd_link  = (inst[11:7] == 5'd1) || (inst[11:7] == 5'd5);
      rs1_link = (inst[19:15] == 5'd1) || (inst[19:15] == 5'd5);
      rd_zero  = (inst[11:7] == 5'd0);
      if (rd_link) begin
         classify = KIND_CALL;
      end else if (!is_jal && rd_zero && rs1_link) begin
         classify = KIND_RET;
      end else begin
         classify = KIND_JUMP;
      end
   endfunction

   entry_t        mem_r [DEPTH];
   entry_t        out_r;
   entry_t        out_nxt_s;
   entry_t        in_entry_s;
   logic [AW:0]   head_r;
   logic [AW:0]   tail_r;
   logic [AW:0]   head_nxt_s;
   logic [AW:0]   tail_nxt_s;
   logic          out_valid_r;
   logic          overflow_r;
   logic [DROPW-1:0] drop_cnt_r;
   logic [1:0]    in_kind_s;
   logic          empty_s;
   logic          full_s;
   logic          deq_s;
   logic          enq_s;
   logic          drop_s;

   // Next-state pointers, accept/drop decisions and the next head entry (bypassing storage when the head slot is written now).
   always_comb begin
      in_kind_s  = classify(in_is_jal, in_inst);
      in_entry_s = {in_pc, in_nextpc, in_inst, in_rd, in_is_jal, in_kind_s};
      empty_s    = (head_r == tail_r);
      full_s     = (head_r[AW] != tail_r[AW]) && (head_r[AW-1:0] == tail_r[AW-1:0]);
      deq_s      = !empty_s && out_ready && !flush;
      enq_s      = in_valid && !flush && (!full_s || deq_s);
      drop_s     = in_valid && !flush && full_s && !deq_s;
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      out_nxt_s  = out_r;
      if (flush) begin
         head_nxt_s = tail_r;
         tail_nxt_s = tail_r;
         out_nxt_s  = out_r;
      end else begin
         head_nxt_s = head_r + {{AW{1'b0}}, deq_s};
         tail_nxt_s = tail_r + {{AW{1'b0}}, enq_s};
         if (enq_s && (head_nxt_s == tail_r)) begin
            out_nxt_s = in_entry_s;
         end else begin
            out_nxt_s = mem_r[head_nxt_s[AW-1:0]];
         end
      end
   end

   // FIFO storage write at the tail.
   always_ff @(posedge clock) begin
      if (enq_s) begin
         mem_r[tail_r[AW-1:0]] <= in_entry_s;
      end
   end

   // Pointers, registered head outputs and drop bookkeeping.
   always_ff @(posedge clock) begin
      if (!reset) begin
         head_r      <= {(AW+1){1'b0}};
         tail_r      <= {(AW+1){1'b0}};
         out_valid_r <= 1'b0;
         out_r       <= ENTRY_ZERO;
         overflow_r  <= 1'b0;
         drop_cnt_r  <= {DROPW{1'b0}};
      end else begin
         head_r      <= head_nxt_s;
         tail_r      <= tail_nxt_s;
         out_valid_r <= (head_nxt_s != tail_nxt_s);
         out_r       <= out_nxt_s;
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != {DROPW{1'b1}}) begin
               drop_cnt_r <= drop_cnt_r + {{(DROPW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

`ifdef FTRACE_DEPTH_EN
   logic [7:0] depth_r;

   // Call depth follows every observed event, including dropped and flushed ones.
   always_ff @(posedge clock) begin
      if (!reset) begin
         depth_r <= 8'd0;
      end else if (in_valid) begin
         case (in_kind_s)
            KIND_CALL: if (depth_r != 8'hFF) depth_r <= depth_r + 8'd1;
            KIND_RET:  if (depth_r != 8'h00) depth_r <= depth_r - 8'd1;
            default:   depth_r <= depth_r;
         endcase
      end
   end

   assign depth = depth_r;
`else
   assign depth = 8'd0;
`endif

   assign out_valid  = out_valid_r;
   assign out_pc     = out_r.pc;
   assign out_nextpc = out_r.nextpc;
   assign out_inst   = out_r.inst;
   assign out_rd     = out_r.rd;
   assign out_is_jal = out_r.is_jal;
   assign out_kind   = out_r.kind;
   assign overflow   = overflow_r;
   assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_ftrace_sched.sv
// Self-checking bench for ftrace_sched: vector table plus scoreboard queue of expected head events.
module tb_ftrace_sched;
   localparam int DEPTH = 8;
   localparam int DROPW = 16;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset, in_valid, in_is_jal, flush, out_valid, out_ready, out_is_jal, overflow;
   logic [31:0] in_pc, in_nextpc, in_inst, in_rd, out_pc, out_nextpc, out_inst, out_rd;
   logic [1:0] out_kind;
   logic [7:0] depth;
   logic [DROPW-1:0] drop_cnt;

   ftrace_sched #(.DEPTH(DEPTH), .DROPW(DROPW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_is_jal(in_is_jal),
      .in_pc(in_pc), .in_nextpc(in_nextpc), .in_inst(in_inst), .in_rd(in_rd),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_nextpc(out_nextpc), .out_inst(out_inst), .out_rd(out_rd),
      .out_is_jal(out_is_jal), .out_kind(out_kind), .depth(depth),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [31:0] pc, np, inst, rd;
      logic        isjal;
      logic [1:0]  kind;
   } ent_t;

   typedef struct {
      logic        v;
      logic        isjal;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  kind;
      logic        rdy;
   } vec_t;

   int total = 0;
   int bad = 0;
   ent_t sb_q[$];
   int drop_m = 0;
   int depth_m = 0;
   logic ovf_m = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic post_checks();
      check("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      check("overflow", 64'(overflow), 64'(ovf_m));
      check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
`ifdef FTRACE_DEPTH_EN
      check("depth", 64'(depth), 64'(depth_m));
`else
      check("depth", 64'(depth), 64'd0);
`endif
   endtask

   // One clock: drive inputs, compare the head on a dequeue, advance the model, check after the edge.
   task automatic cycle(input logic v, input logic isjal, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [1:0] kind, input logic rdy, input logic fl);
      ent_t e;
      int occ;
      logic deq;
      in_valid = v; in_is_jal = isjal; in_pc = pc; in_nextpc = pc + 32'd8;
      in_inst = inst; in_rd = pc + 32'd4; out_ready = rdy; flush = fl;
      occ = sb_q.size();
      deq = (occ > 0) && rdy && !fl;
      if (deq) begin
         e = sb_q[0];
         check("head_pc", 64'(out_pc), 64'(e.pc));
         check("head_nextpc", 64'(out_nextpc), 64'(e.np));
         check("head_inst", 64'(out_inst), 64'(e.inst));
         check("head_rd", 64'(out_rd), 64'(e.rd));
         check("head_is_jal", 64'(out_is_jal), 64'(e.isjal));
         check("head_kind", 64'(out_kind), 64'(e.kind));
      end
      if (fl) begin
         sb_q.delete();
      end else begin
         if (deq) void'(sb_q.pop_front());
         if (v) begin
            if (occ < DEPTH || deq) begin
               e.pc = pc; e.np = pc + 32'd8; e.inst = inst; e.rd = pc + 32'd4;
               e.isjal = isjal; e.kind = kind;
               sb_q.push_back(e);
            end else begin
               ovf_m = 1'b1;
               if (drop_m < (2**DROPW - 1)) drop_m++;
            end
         end
      end
      if (v) begin
         if (kind == 2'b01 && depth_m < 255) depth_m++;
         else if (kind == 2'b10 && depth_m > 0) depth_m--;
      end
      @(posedge clock);
      #1;
      post_checks();
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, rdy, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      sb_q.delete();
      drop_m = 0; ovf_m = 1'b0; depth_m = 0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_kind", 64'(out_kind), 64'd0);
      check("rst_depth", 64'(depth), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b1, 1'b1, 32'h8000_0000, 32'h0080_00EF, 2'b01, 1'b1}; // jal x1: call
      vecs[1] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0000_8067, 2'b10, 1'b1}; // jalr x0,0(x1): return
      vecs[2] = '{1'b1, 1'b1, 32'h8000_0020, 32'h0000_006F, 2'b00, 1'b0}; // jal x0: jump
      vecs[3] = '{1'b1, 1'b1, 32'h8000_0030, 32'h0000_02EF, 2'b01, 1'b0}; // jal x5: call
      vecs[4] = '{1'b1, 1'b0, 32'h8000_0040, 32'h0002_8067, 2'b10, 1'b1}; // jalr x0,0(x5): return
      vecs[5] = '{1'b1, 1'b0, 32'h8000_0050, 32'h0002_80E7, 2'b01, 1'b1}; // jalr x1,0(x5): call
      vecs[6] = '{1'b1, 1'b0, 32'h8000_0060, 32'h0003_0067, 2'b00, 1'b1}; // jalr x0,0(x6): jump
      vecs[7] = '{1'b1, 1'b1, 32'h8000_0070, 32'h0000_806F, 2'b00, 1'b1}; // jal x0 with rs1 bits = 1: jump
      vecs[8] = '{1'b1, 1'b0, 32'h8000_0080, 32'h0000_8167, 2'b00, 1'b1}; // jalr x2,0(x1): jump
      vecs[9] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00, 1'b1};

      reset = 1'b0; in_valid = 1'b0; in_is_jal = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_pc = 32'h0; in_nextpc = 32'h0; in_inst = 32'h0; in_rd = 32'h0;
      repeat (2) @(posedge clock);
      do_reset();

      // Single call, return, extra return saturating at zero
      cycle(1'b1, 1'b1, 32'h8000_0000, 32'h0080_00EF, 2'b01, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 32'h8000_0008, 32'h0000_8067, 2'b10, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 32'h8000_000C, 32'h0000_8067, 2'b10, 1'b1, 1'b0);
      repeat (2) idle(1'b1);

      // Classification vectors
      for (int i = 0; i < 10; i++)
         cycle(vecs[i].v, vecs[i].isjal, vecs[i].pc, vecs[i].inst, vecs[i].kind, vecs[i].rdy, 1'b0);
      repeat (3) idle(1'b1);

      // Fill and drop: 10 events with sink stalled, then drain 8
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 1'b1, 32'h9000_0000 + 32'(i * 16), 32'h0000_006F, 2'b00, 1'b0, 1'b0);
      check("fill_occ", 64'(sb_q.size()), 64'd8);
      for (int i = 0; i < 9; i++) idle(1'b1);

      // Full with simultaneous dequeue for 5 cycles: nothing dropped
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 1'b1, 32'hA000_0000 + 32'(i * 16), 32'h0000_02EF, 2'b01, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 1'b0, 32'hB000_0000 + 32'(i * 16), 32'h0002_8067, 2'b10, 1'b1, 1'b0);
      check("full_deq_occ", 64'(sb_q.size()), 64'd8);
      check("full_deq_drop", 64'(drop_cnt), 64'd2);
      for (int i = 0; i < 9; i++) idle(1'b1);

      // Flush together with an incoming call
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b1, 32'hC000_0000 + 32'(i * 16), 32'h0000_006F, 2'b00, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'hC000_0100, 32'h0080_00EF, 2'b01, 1'b1, 1'b1);
      check("flush_empty", 64'(out_valid), 64'd0);
      idle(1'b1);

      // Reset mid-drain, then a lone event
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'b1, 32'hD000_0000 + 32'(i * 16), 32'h0080_00EF, 2'b01, 1'b0, 1'b0);
      idle(1'b1);
      do_reset();
      cycle(1'b1, 1'b1, 32'hE000_0000, 32'h0000_006F, 2'b00, 1'b0, 1'b0);
      check("post_rst_one", 64'(sb_q.size()), 64'd1);
      idle(1'b1);
      repeat (2) idle(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
